// File: rtl/tiny45_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tiny45_sequencer
//  Description : Cycle sequencer for the nibble-serial tiny45 core. Latches
//                instructions, runs 8-cycle nibble passes, stalls on load and
//                store handshakes and owns the program counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tiny45_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_instr_in,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  output logic [31:0] o_instr,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [1:0]  i_instr_len,
  input  logic        i_branch,
  input  logic [3:0]  i_addr_nibble,
  input  logic        i_load_data_ready,
  input  logic        i_mem_ack,
  output logic [2:0]  o_counter,
  output logic        o_core_en,
  output logic        o_wb_pass,
  output logic [31:0] o_pc,
  output logic [3:0]  o_pc_nibble,
  output logic [3:0]  o_next_pc_nibble,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_retire,
  output logic        o_flush
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_EXEC       = 3'd1,
    S_LOAD_WAIT  = 3'd2,
    S_WB         = 3'd3,
    S_STORE_WAIT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_counter;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_mem_addr;
  // Only nibbles 0..6 need storage; nibble 7 arrives live on the last cycle.
  logic [27:0] r_target;
  logic        r_retire;
  logic        r_flush;

  logic [31:0] w_pc_inc;
  logic [31:0] w_full_target;
  logic        w_last;
  logic        w_in_exec;
  logic        w_accept;
  logic        w_cnt_clr;
  logic        w_retire_nxt;
  logic        w_flush_nxt;
  logic        w_pc_step;
  logic        w_pc_jump;
  logic        w_addr_load;

  assign w_pc_inc      = r_pc + {29'd0, i_instr_len, 1'b0};
  assign w_full_target = {i_addr_nibble, r_target};
  assign w_last        = (r_counter == 3'd7);
  assign w_in_exec     = (r_state == S_EXEC);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and per-state control/outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_cnt_clr     = 1'b0;
    w_retire_nxt  = 1'b0;
    w_flush_nxt   = 1'b0;
    w_pc_step     = 1'b0;
    w_pc_jump     = 1'b0;
    w_addr_load   = 1'b0;
    o_instr_ready = 1'b0;
    o_core_en     = 1'b0;
    o_wb_pass     = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_instr_ready = 1'b1;
        if (i_instr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        o_core_en = 1'b1;
        if (w_last) begin
          // Load takes priority over store; branch is only honoured for ALU ops.
          if (i_is_load) begin
            w_addr_load = 1'b1;
            w_state_nxt = S_LOAD_WAIT;
          end else if (i_is_store) begin
            w_addr_load = 1'b1;
            w_state_nxt = S_STORE_WAIT;
          end else begin
            w_retire_nxt = 1'b1;
            w_flush_nxt  = i_branch;
            w_pc_jump    = i_branch;
            w_pc_step    = ~i_branch;
            w_state_nxt  = S_IDLE;
          end
        end
      end
      S_LOAD_WAIT: begin
        o_mem_read = 1'b1;
        if (i_load_data_ready) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        o_core_en = 1'b1;
        o_wb_pass = 1'b1;
        if (w_last) begin
          w_pc_step    = 1'b1;
          w_retire_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      S_STORE_WAIT: begin
        o_mem_write = 1'b1;
        if (i_mem_ack) begin
          w_pc_step    = 1'b1;
          w_retire_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: instruction latch, nibble counter, target, PC, address
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_counter  <= 3'd0;
      r_instr    <= 32'd0;
      r_pc       <= RESET_PC;
      r_mem_addr <= 32'd0;
      r_target   <= 28'd0;
      r_retire   <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_retire <= w_retire_nxt;
      r_flush  <= w_flush_nxt;
      if (w_accept) r_instr <= i_instr_in;
      if (w_accept || w_cnt_clr) r_counter <= 3'd0;
      else if (o_core_en)        r_counter <= r_counter + 3'd1;
      // Nibbles arrive LSB first, so shifting in from the top leaves
      // nibble k at bits [4k+3:4k] after seven shifts.
      if (w_in_exec && !w_last) r_target <= {i_addr_nibble, r_target[27:4]};
      if (w_addr_load) r_mem_addr <= w_full_target;
      if (w_pc_jump)      r_pc <= w_full_target;
      else if (w_pc_step) r_pc <= w_pc_inc;
    end
  end

  assign o_counter        = r_counter;
  assign o_instr          = r_instr;
  assign o_pc             = r_pc;
  assign o_mem_addr       = r_mem_addr;
  assign o_retire         = r_retire;
  assign o_flush          = r_flush;
  assign o_pc_nibble      = r_pc[{r_counter, 2'b00} +: 4];
  assign o_next_pc_nibble = w_pc_inc[{r_counter, 2'b00} +: 4];

endmodule
`default_nettype wire

// File: tb/tb_tiny45_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tiny45_sequencer
//  Description : Scoreboard bench for tiny45_sequencer. Directed instructions
//                push expected retire results; a monitor checks each retire.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tiny45_sequencer;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] i_instr_in = '0;
  logic        i_instr_valid = 1'b0;
  logic        i_is_load = 1'b0;
  logic        i_is_store = 1'b0;
  logic [1:0]  i_instr_len = '0;
  logic        i_branch = 1'b0;
  logic [3:0]  i_addr_nibble = '0;
  logic        i_load_data_ready = 1'b0;
  logic        i_mem_ack = 1'b0;
  logic        o_instr_ready;
  logic [31:0] o_instr;
  logic [2:0]  o_counter;
  logic        o_core_en;
  logic        o_wb_pass;
  logic [31:0] o_pc;
  logic [3:0]  o_pc_nibble;
  logic [3:0]  o_next_pc_nibble;
  logic [31:0] o_mem_addr;
  logic        o_mem_read;
  logic        o_mem_write;
  logic        o_retire;
  logic        o_flush;

  tiny45_sequencer #(.RESET_PC(c_RESET_PC)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_instr_in       (i_instr_in),
    .i_instr_valid    (i_instr_valid),
    .o_instr_ready    (o_instr_ready),
    .o_instr          (o_instr),
    .i_is_load        (i_is_load),
    .i_is_store       (i_is_store),
    .i_instr_len      (i_instr_len),
    .i_branch         (i_branch),
    .i_addr_nibble    (i_addr_nibble),
    .i_load_data_ready(i_load_data_ready),
    .i_mem_ack        (i_mem_ack),
    .o_counter        (o_counter),
    .o_core_en        (o_core_en),
    .o_wb_pass        (o_wb_pass),
    .o_pc             (o_pc),
    .o_pc_nibble      (o_pc_nibble),
    .o_next_pc_nibble (o_next_pc_nibble),
    .o_mem_addr       (o_mem_addr),
    .o_mem_read       (o_mem_read),
    .o_mem_write      (o_mem_write),
    .o_retire         (o_retire),
    .o_flush          (o_flush)
  );

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] pc_m = c_RESET_PC;

  always #5 clk = ~clk;

  // Cycle index: increments at each rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every retire pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (o_retire) begin
      if (q.size() == 0) begin
        chk("unexpected_retire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("retire_pc", o_pc, e.pc);
        chk("retire_flush", {31'd0, o_flush}, {31'd0, e.flush});
        chk("retire_cycle", cyc, e.cyc);
        chk("retire_ready", {31'd0, o_instr_ready}, 32'd1);
      end
    end else if (o_flush) begin
      chk("flush_without_retire", 32'd1, 32'd0);
    end
  end

  // Issue one instruction starting in the current (IDLE) cycle T, then drive
  // the 8 EXEC nibbles. Returns 1ns after the edge that starts cycle T+9.
  task automatic issue(input logic [31:0] word, input logic [31:0] tgt,
                       input logic br, input logic ld, input logic st,
                       input logic [1:0] len, input logic hold, input logic detail);
    int          t0;
    logic [31:0] old_pc;
    logic [31:0] inc_pc;
    exp_t        e;
    t0     = cyc;
    old_pc = pc_m;
    inc_pc = pc_m + {29'd0, len, 1'b0};
    i_instr_in    = word;
    i_instr_valid = 1'b1;
    i_is_load     = ld;
    i_is_store    = st;
    i_instr_len   = len;
    i_branch      = 1'b0;
    if (!ld && !st) begin
      pc_m    = br ? tgt : inc_pc;
      e.pc    = pc_m;
      e.flush = br;
      e.cyc   = t0 + 9;
      q.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (!hold) i_instr_valid = 1'b0;
      i_addr_nibble = tgt[4*k +: 4];
      i_branch      = (k == 7) ? br : 1'b0;
      @(negedge clk);
      chk("exec_core_en", {31'd0, o_core_en}, 32'd1);
      if (detail) begin
        chk("exec_counter", {29'd0, o_counter}, k);
        chk("exec_pc_nibble", {28'd0, o_pc_nibble}, {28'd0, old_pc[4*k +: 4]});
        chk("exec_next_pc_nibble", {28'd0, o_next_pc_nibble}, {28'd0, inc_pc[4*k +: 4]});
        if (k == 0) chk("exec_instr", o_instr, word);
      end
      if (hold) chk("busy_not_ready", {31'd0, o_instr_ready}, 32'd0);
    end
    @(posedge clk); #1;
    i_branch = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   tl;
    // Reset
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, o_instr_ready}, 32'd1);
    chk("rst_core_en", {31'd0, o_core_en}, 32'd0);
    chk("rst_wb_pass", {31'd0, o_wb_pass}, 32'd0);
    chk("rst_mem_rw", {30'd0, o_mem_read, o_mem_write}, 32'd0);
    chk("rst_retire_flush", {30'd0, o_retire, o_flush}, 32'd0);
    chk("rst_pc", o_pc, c_RESET_PC);
    chk("rst_counter", {29'd0, o_counter}, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    @(posedge clk); #1;

    // ALU, instr_len=2: 0x100 -> 0x104, no flush
    issue(32'hA1A1_0001, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    chk("alu_pc", o_pc, 32'h0000_0104);
    @(posedge clk); #1;

    // Taken branch to 0x20, flush exactly one cycle
    issue(32'hB2B2_0002, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk("br_flush_hi", {31'd0, o_flush}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("br_flush_lo", {31'd0, o_flush}, 32'd0);
    chk("br_pc_hold", o_pc, 32'h0000_0020);
    @(posedge clk); #1;

    // Load (store flag and branch also set: load wins, branch ignored)
    tl = cyc;
    issue(32'hC3C3_0003, 32'h1000_0040, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    pc_m    = pc_m + 32'd2;
    e.pc    = pc_m;
    e.flush = 1'b0;
    e.cyc   = tl + 21;
    q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) i_load_data_ready = 1'b1;
      @(negedge clk);
      chk("ld_mem_read", {31'd0, o_mem_read}, 32'd1);
      if (i == 0) begin
        chk("ld_mem_addr", o_mem_addr, 32'h1000_0040);
        chk("ld_no_write", {31'd0, o_mem_write}, 32'd0);
      end
      @(posedge clk); #1;
    end
    i_load_data_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("wb_pass", {31'd0, o_wb_pass}, 32'd1);
      chk("wb_counter", {29'd0, o_counter}, k);
      if (k == 0) chk("wb_mem_read_lo", {31'd0, o_mem_read}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ld_mem_addr_stable", o_mem_addr, 32'h1000_0040);
    @(posedge clk); #1;

    // Store acknowledged in the same cycle mem_write rises
    tl = cyc;
    issue(32'hD4D4_0004, 32'h2000_0008, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    i_mem_ack = 1'b1;
    pc_m    = pc_m + 32'd4;
    e.pc    = pc_m;
    e.flush = 1'b0;
    e.cyc   = tl + 10;
    q.push_back(e);
    @(negedge clk);
    chk("st_mem_write_hi", {31'd0, o_mem_write}, 32'd1);
    chk("st_mem_addr", o_mem_addr, 32'h2000_0008);
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    @(negedge clk);
    chk("st_mem_write_lo", {31'd0, o_mem_write}, 32'd0);
    chk("st_pc", o_pc, 32'h0000_0026);
    @(posedge clk); #1;

    // PC wrap with instr_valid held high across back-to-back instructions
    issue(32'hE5E5_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    issue(32'hF6F6_0006, 32'h0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    i_instr_valid = 1'b0;
    @(negedge clk);
    chk("wrap_pc", o_pc, 32'd0);
    chk("wrap_ready", {31'd0, o_instr_ready}, 32'd1);
    @(posedge clk); #1;

    // Reset asserted during LOAD_WAIT
    issue(32'h1717_0007, 32'h3000_0000, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rl_mem_read_hi", {31'd0, o_mem_read}, 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    pc_m = c_RESET_PC;
    @(negedge clk);
    chk("rl_mem_read_lo", {31'd0, o_mem_read}, 32'd0);
    chk("rl_pc", o_pc, c_RESET_PC);
    chk("rl_ready", {31'd0, o_instr_ready}, 32'd1);
    chk("rl_no_retire", {31'd0, o_retire}, 32'd0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("pending_retires", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tiny45_sequencer.md
# tiny45_sequencer

Cycle sequencer for the nibble-serial tiny45 core. It accepts instruction words from the fetch buffer and latches them for the decoder. It runs the core through 8-cycle nibble passes, stalls on load/store memory handshakes and owns the PC, including sequential increment, taken-branch redirect and fetch flush.

## Interface

- RESET_PC, 32'h0000_0000, PC value after reset
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- instr_in  in  32  instruction word from fetch buffer
- instr_valid  in  1  instr_in valid
- instr_ready  out  1  sequencer can accept an instruction (high only in IDLE)
- instr  out  32  latched instruction to decoder
- is_load, is_store  in  1 each  decoder class flags for `instr`
- instr_len  in  2  decoder length field; PC increment in bytes = {instr_len,1'b0}
- branch  in  1  core branch-taken, sampled only at counter==7 of the EXEC pass
- addr_nibble  in  4  core address/target nibble for current counter
- load_data_ready  in  1  read data available (memory side)
- mem_ack  in  1  store accepted (memory side)
- counter  out  3  nibble index 0..7 of current pass
- core_en  out  1  core advances this cycle (EXEC or WB)
- wb_pass  out  1  high during load write-back pass
- pc  out  32  current PC
- pc_nibble, next_pc_nibble  out  4 each  pc[4*counter+:4], (pc+{instr_len,1'b0})[4*counter+:4]
- mem_addr  out  32  load/store address, registered at end of EXEC
- mem_read, mem_write  out  1 each  memory request levels
- retire  out  1  one-cycle pulse: instruction complete
- flush  out  1  one-cycle pulse with retire on taken branch

## Operation

- States: IDLE, EXEC, LOAD_WAIT, WB, STORE_WAIT.
- IDLE: instr_ready=1. On instr_valid, latch instr_in into instr, set counter=0 and go to EXEC.
- EXEC: core_en=1. counter increments by 1 per cycle. Each cycle, target_reg[4*counter+:4] <= addr_nibble. At counter==7:
  - is_load: mem_addr <= {addr_nibble, target_reg[27:0]}; go to LOAD_WAIT. is_load wins if is_store is also set.
  - is_store: mem_addr <= {addr_nibble, target_reg[27:0]}; go to STORE_WAIT.
  - Otherwise: pc <= branch ? {addr_nibble, target_reg[27:0]} : pc + {instr_len,1'b0}; retire<=1; flush<=branch; go to IDLE.
- The branch input is ignored for loads and stores.
- LOAD_WAIT: mem_read=1. When load_data_ready is sampled high: counter=0, go to WB.
- WB: core_en=1, wb_pass=1, counter 0..7. At counter==7: pc <= pc+{instr_len,1'b0}; retire<=1; go to IDLE.
- STORE_WAIT: mem_write=1. When mem_ack is sampled high: pc <= pc+{instr_len,1'b0}; retire<=1; go to IDLE.
- PC arithmetic is mod 2^32 and has no alignment check. For example, 32'hFFFF_FFFC+4 = 0.
- instr_valid outside IDLE, load_data_ready outside LOAD_WAIT and mem_ack outside STORE_WAIT are all ignored.

## Timing

- Reset values: state=IDLE, pc=RESET_PC, counter=0, instr=0, mem_addr=0, target_reg=0. Outputs after reset: instr_ready=1, core_en=0, wb_pass=0, mem_read=0, mem_write=0, retire=0, flush=0.
- A reset mid-operation abandons everything: the pending request drops the next cycle and no retire is produced.
- ALU/branch instruction, accepted at cycle T:
  - EXEC runs T+1..T+8 with counter 0..7.
  - In T+9: retire and flush are high, the new pc is visible, and instr_ready=1.
  - Back-to-back throughput is 9 cycles per instruction.
- Load:
  - mem_read rises at T+9.
  - load_data_ready high in cycle L (L ≥ T+9) starts WB in L+1..L+8.
  - retire fires at L+9.
  - mem_read drops at L+1.
- Store:
  - mem_write rises at T+9.
  - mem_ack high in cycle A gives retire at A+1; mem_write drops at A+1.
- mem_addr is stable from T+9 until the next EXEC completes.
- retire and flush are registered pulses, exactly one cycle each.

## Test plan

- Reset with RESET_PC=32'h100, then issue ALU instr with instr_len=2 at T. Expect counter 0..7 on T+1..T+8, retire at T+9, pc=32'h104, flush=0.
- Taken branch: addr_nibble sequence 0,2,0,0,0,0,0,0 with branch=1 at counter 7. Expect pc=32'h20 at T+9 and flush pulse one cycle.
- Load: addr nibbles form 32'h1000_0040, and load_data_ready is delayed 3 cycles. Expect:
  - mem_read high T+9..T+12, mem_addr=32'h1000_0040.
  - WB with wb_pass=1 on T+13..T+20.
  - retire at T+21.
- Store with mem_ack in the same cycle as the rising edge of mem_write (T+9). Expect retire at T+10 and mem_write for exactly one cycle.
- PC wrap: pc=32'hFFFF_FFFE with instr_len=1 retires to pc=0. Hold instr_valid high throughout and expect instr_ready low except IDLE cycles.
- Reset asserted during LOAD_WAIT. Expect mem_read=0, pc=RESET_PC and instr_ready=1 in the next cycle, with no retire.
